// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and iteration-count helper for the sequential divider.
package div_pkg;

  localparam int DW = 16;
  localparam int VW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Number of restoring steps once K dividend LSBs have been discarded.
  function automatic int div_iters(input int k);
    return DW - k;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and report the quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [VW:0]   p,
  input  logic          bit_in,
  input  logic [VW-1:0] b,
  output logic [VW:0]   p_next,
  output logic          qbit
);

  logic [VW+1:0] trial;
  logic [VW+1:0] diff;

  // The partial remainder stays below the divisor, so the trial never reaches
  // bit VW+1 and the top bit of the difference is exactly the borrow.
  always_comb begin
    trial  = {p, bit_in};
    diff   = trial - {2'b00, b};
    qbit   = ~diff[VW+1];
    p_next = qbit ? diff[VW:0] : trial[VW:0];
  end

endmodule

// File: rtl/div16by8_seq.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock.
// APPROX_LSBS drops low dividend bits to shorten the iteration count.
module div16by8_seq
  import div_pkg::*;
#(
  parameter int APPROX_LSBS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          dbz
);

  localparam int              N         = div_iters(APPROX_LSBS);
  localparam int              CW        = $clog2(DW + 1);
  localparam logic [CW-1:0]   LAST_STEP = CW'(N - 1);
  localparam logic [DW-1:0]   KEEP_MASK = {DW{1'b1}} << APPROX_LSBS;

  if (APPROX_LSBS < 0 || APPROX_LSBS > VW) begin : g_bad_k
    $error("div16by8_seq: APPROX_LSBS must be in 0..8");
  end

  div_state_t      state;
  logic [DW-1:0]   dvd_reg;
  logic [VW-1:0]   dvs_reg;
  logic [VW:0]     p_reg;
  logic [VW:0]     p_next;
  logic [DW-2:0]   quo_reg;
  logic [DW-1:0]   quo_next;
  logic [CW-1:0]   step_cnt;
  logic            qbit;

  div_step u_step (
    .p      (p_reg),
    .bit_in (dvd_reg[DW-1]),
    .b      (dvs_reg),
    .p_next (p_next),
    .qbit   (qbit)
  );

  assign quo_next  = {quo_reg, qbit};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The dividend is kept MSB-aligned with its dropped LSBs zeroed, so every
  // step simply consumes bit DW-1 and shifts left; the quotient grows from
  // the LSB and is re-aligned by K when the result is published.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dvd_reg  <= '0;
      dvs_reg  <= '0;
      p_reg    <= '0;
      quo_reg  <= '0;
      step_cnt <= '0;
      Q        <= '0;
      R        <= '0;
      dbz      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_reg  <= A & KEEP_MASK;
            dvs_reg  <= B;
            p_reg    <= '0;
            quo_reg  <= '0;
            step_cnt <= '0;
            if (B == '0) begin
              Q     <= '1;
              R     <= VW'(A >> APPROX_LSBS);
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          p_reg    <= p_next;
          quo_reg  <= quo_next[DW-2:0];
          dvd_reg  <= {dvd_reg[DW-2:0], 1'b0};
          step_cnt <= step_cnt + CW'(1);
          if (step_cnt == LAST_STEP) begin
            Q     <= quo_next << APPROX_LSBS;
            R     <= p_next[VW-1:0];
            dbz   <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
